// File: rtl/imgrad_row_feeder_if.sv
// Control, memory-port and column-triple stream bundle between imgrad_row_feeder and its neighbours.
// Latency: none, wiring only.
// Backpressure: none; the stream is gap-free and the memory answers every read one cycle later.
interface imgrad_row_feeder_if #(
    parameter int PW = 12,
    parameter int AW = 19,
    parameter int CW = 10
);
    logic          start;
    logic [CW-1:0] center_r;
    logic [CW-1:0] center_c;
    logic          busy;
    logic          done;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_data;
    logic [PW-1:0] in0;
    logic [PW-1:0] in1;
    logic [PW-1:0] in2;
    logic          enable;
    logic          imgrad_rst;

    // Environment side: pyramid controller, level image memory, imgrad.
    modport master (
        output start, center_r, center_c, mem_data,
        input  busy, done, mem_rd, mem_addr, in0, in1, in2, enable, imgrad_rst
    );

    // Feeder side.
    modport slave (
        input  start, center_r, center_c, mem_data,
        output busy, done, mem_rd, mem_addr, in0, in1, in2, enable, imgrad_rst
    );
endinterface

// File: rtl/imgrad_row_feeder.sv
// Fetches a clamped (WIN+2)^2 patch around a centre into three rotating line buffers and streams column triples.
// Latency: start at cycle 0 -> imgrad_rst at 1, preload reads 2..3*PE+1, stream from 3*PE+3 for WIN*PE cycles, done next.
// Backpressure: none; start is only accepted in IDLE, the stream never stalls.
module imgrad_row_feeder #(
    parameter int WIN   = 7,
    parameter int PW    = 12,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int AW    = 19,
    parameter int CW    = 10
) (
    input  logic               clk,
    input  logic               reset,
    imgrad_row_feeder_if.slave io
);
    localparam int HALF = WIN / 2;
    localparam int PE   = WIN + 2;
    localparam int RW   = $clog2(WIN + 1);
    localparam int CLW  = $clog2(PE);
    localparam int CWP  = CW + 1;

    localparam logic [RW-1:0]         ROW_WAIT   = RW'(3);
    localparam logic [RW-1:0]         ROW_LAST   = RW'(WIN - 1);
    localparam logic [RW-1:0]         FETCH_LAST = RW'(WIN - 2);
    localparam logic [CLW-1:0]        COL_LAST   = CLW'(PE - 1);
    localparam logic signed [CW:0]    OFS        = CWP'(HALF + 1);
    localparam logic signed [CW:0]    RMAX       = CWP'(IMG_H - 1);
    localparam logic signed [CW:0]    CMAX       = CWP'(IMG_W - 1);
    localparam logic [AW-1:0]         ROW_PITCH  = AW'(IMG_W);

    typedef enum logic [2:0] {IDLE, CLEAR, PRELOAD, STREAM, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cen_r;
    logic [CW-1:0]      cen_c;
    logic [RW-1:0]      row_cnt;    // patch row in PRELOAD (ROW_WAIT = wait cycle), output row k in STREAM
    logic [CLW-1:0]     col_cnt;    // patch column j
    logic [1:0]         base;       // buffer holding patch row k, i.e. k mod 3
    logic [1:0]         b1;
    logic [1:0]         b2;
    logic [PW-1:0]      lbuf [3][PE];

    logic               busy;
    logic               done;
    logic               clr;
    logic               enable;
    logic               fetch;
    logic [1:0]         fetch_buf;
    logic [CW:0]        fetch_row;
    logic signed [CW:0] img_r;
    logic signed [CW:0] img_c;
    logic [CW-1:0]      cl_r;
    logic [CW-1:0]      cl_c;
    logic [AW-1:0]      addr;

    logic               wr_vld;
    logic [1:0]         wr_buf;
    logic [CLW-1:0]     wr_col;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and control outputs.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        clr       = 1'b0;
        enable    = 1'b0;
        fetch     = 1'b0;
        case (state)
            IDLE: begin
                if (io.start) state_nxt = CLEAR;
            end
            CLEAR: begin
                busy      = 1'b1;
                clr       = 1'b1;
                state_nxt = PRELOAD;
            end
            PRELOAD: begin
                busy  = 1'b1;
                fetch = (row_cnt != ROW_WAIT);
                if (row_cnt == ROW_WAIT) state_nxt = STREAM;
            end
            STREAM: begin
                busy   = 1'b1;
                enable = 1'b1;
                // Refill row k+3 into the buffer row k is vacating; last row has nothing left to fetch.
                fetch  = (row_cnt <= FETCH_LAST);
                if (row_cnt == ROW_LAST && col_cnt == COL_LAST) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Centre capture on acceptance.
    always_ff @(posedge clk) begin
        if (state == IDLE && io.start) begin
            cen_r <= io.center_r;
            cen_c <= io.center_c;
        end
    end

    // Row/column sequencing and buffer rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            row_cnt <= '0;
            col_cnt <= '0;
            base    <= '0;
        end else begin
            case (state)
                PRELOAD: begin
                    if (row_cnt == ROW_WAIT) begin
                        row_cnt <= '0;
                        col_cnt <= '0;
                    end else if (col_cnt == COL_LAST) begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
                STREAM: begin
                    if (col_cnt == COL_LAST) begin
                        col_cnt <= '0;
                        row_cnt <= row_cnt + 1'b1;
                        base    <= b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
                default: begin
                    row_cnt <= '0;
                    col_cnt <= '0;
                    base    <= '0;
                end
            endcase
        end
    end

    assign b1 = (base == 2'd2) ? 2'd0 : base + 2'd1;
    assign b2 = (base == 2'd0) ? 2'd2 : base - 2'd1;

    // Fetch address: patch coordinate -> image coordinate with border replication.
    always_comb begin
        fetch_buf = (state == PRELOAD) ? row_cnt[1:0] : base;
        fetch_row = (state == PRELOAD) ? CWP'(row_cnt) : CWP'(row_cnt) + CWP'(3);
        img_r     = $signed({1'b0, cen_r}) + $signed(fetch_row) - OFS;
        img_c     = $signed({1'b0, cen_c}) + $signed(CWP'(col_cnt)) - OFS;
        if (img_r < 0)          cl_r = '0;
        else if (img_r > RMAX)  cl_r = RMAX[CW-1:0];
        else                    cl_r = img_r[CW-1:0];
        if (img_c < 0)          cl_c = '0;
        else if (img_c > CMAX)  cl_c = CMAX[CW-1:0];
        else                    cl_c = img_c[CW-1:0];
        addr = {{(AW-CW){1'b0}}, cl_r} * ROW_PITCH + {{(AW-CW){1'b0}}, cl_c};
    end

    // Track where the read issued this cycle lands next cycle; reset drops in-flight data.
    always_ff @(posedge clk) begin
        if (reset) wr_vld <= 1'b0;
        else       wr_vld <= fetch;
        wr_buf <= fetch_buf;
        wr_col <= col_cnt;
    end

    // Line buffer write. A column is rewritten the cycle after it was streamed.
    always_ff @(posedge clk) begin
        if (wr_vld) lbuf[wr_buf][wr_col] <= io.mem_data;
    end

    assign io.busy       = busy;
    assign io.done       = done;
    assign io.imgrad_rst = clr;
    assign io.enable     = enable;
    assign io.mem_rd     = fetch;
    assign io.mem_addr   = fetch ? addr : '0;
    assign io.in0        = enable ? lbuf[base][col_cnt] : '0;
    assign io.in1        = enable ? lbuf[b1][col_cnt]   : '0;
    assign io.in2        = enable ? lbuf[b2][col_cnt]   : '0;
endmodule

// File: doc/imgrad_row_feeder.md
Name: imgrad_row_feeder

Overview:
- Upstream stage of imgrad. Accepts a feature-point centre from the pyramid controller.
- Fetches the (WIN+2)x(WIN+2) pixel patch around that centre from the level image memory (single read port, 1-cycle read latency) into three rotating line buffers.
- Streams gap-free column triples (row above, row, row below) for the WIN output rows on in0/in1/in2.
- Drives imgrad's enable and imgrad_rst so each window's gradient sums start from zero.

Parameters:
- WIN, 7, window size (odd); HALF = WIN/2 = 3; patch edge PE = WIN+2 = 9.
- PW, 12, pixel width.
- IMG_W, 640, image width in pixels.
- IMG_H, 480, image height in pixels.
- AW, 19, memory address width; address = row*IMG_W + col.
- CW, 10, coordinate width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous active-high reset.
- start  in  1  request pulse, sampled only in IDLE.
- center_r  in  CW  centre row, captured with start.
- center_c  in  CW  centre column, captured with start.
- busy  out  1  high from acceptance until done inclusive.
- done  out  1  one-cycle pulse after the last stream cycle.
- mem_rd  out  1  read strobe.
- mem_addr  out  AW  read address, valid when mem_rd=1.
- mem_data  in  PW  read data, valid the cycle after mem_rd.
- in0  out  PW  pixel at patch row k, column j.
- in1  out  PW  pixel at patch row k+1, column j.
- in2  out  PW  pixel at patch row k+2, column j.
- enable  out  1  stream valid; drives imgrad enable.
- imgrad_rst  out  1  one-cycle clear pulse to imgrad accumulators.

Behaviour:
- Reset (synchronous): state IDLE. All outputs are 0: busy, done, mem_rd, mem_addr, in0..in2, enable, imgrad_rst. Line buffers need not be cleared.
- Reset mid-operation:
  - Takes effect at the next edge. State returns to IDLE and all outputs are 0 the following cycle.
  - No done pulse is issued. Any in-flight read data is discarded.
- Patch geometry:
  - Patch row p = 0..PE-1 maps to image row center_r - HALF - 1 + p.
  - Patch column j = 0..PE-1 maps to image column center_c - HALF - 1 + j.
  - Coordinates are clamped independently to [0, IMG_H-1] and [0, IMG_W-1] (border replication). Clamping uses signed arithmetic of width CW+1.
- States: IDLE, CLEAR, PRELOAD, STREAM, DONE.
- IDLE:
  - start=1 captures the centre and moves to CLEAR; busy rises the next cycle.
  - start is ignored in every other state.
- CLEAR: exactly 1 cycle with imgrad_rst=1, then PRELOAD.
- PRELOAD:
  - Issues 3*PE consecutive reads (one per cycle), patch rows 0, 1, 2, each column 0..PE-1.
  - Then one wait cycle for the last data, then STREAM.
- STREAM:
  - Lasts exactly WIN*PE consecutive cycles with enable=1 and no gaps.
  - Output row k = 0..WIN-1 occupies PE cycles, j = 0..PE-1 in order; in0/in1/in2 carry patch rows k, k+1, k+2 at column j.
  - While row k streams (k <= WIN-2), patch row k+3 is fetched, at most one read per cycle, into the buffer vacated by row k.
  - A column may be overwritten only after it has been output.
  - No reads occur during the last output row.
- DONE:
  - One cycle with done=1 and busy=1, then IDLE.
  - A start on that same cycle is ignored; it is accepted from IDLE on the next cycle.
- Timing, with start sampled at cycle 0 and WIN=7:
  - imgrad_rst=1 at cycle 1.
  - PRELOAD reads at cycles 2..28.
  - enable=1 at cycles 30..92.
  - done=1 at cycle 93.
  - busy=1 at cycles 1..93.
- Outputs when enable=0: in0..in2 held at 0. mem_addr is 0 whenever mem_rd=0.
- Total reads per window: PE*PE = 81.

Test Plan:
- Ramp image, pixel(r,c) = (r*16 + c) mod 4096, centre (100,200): first enable cycle is 30 with in0=pixel(96,196), in1=pixel(97,196), in2=pixel(98,196). Last enable cycle is 92 with in2=pixel(104,204). Exactly 63 enable cycles, done at 93, 81 reads total.
- Corner clamp, centre (0,0): patch rows/cols -4..4 clamp to 0..4. The first 5 columns of every triple equal column 0, and the in0 of the first output row equals image row 0.
- Far corner, centre (479,639): no mem_addr ever exceeds 479*640 + 639 = 307199. The last-row in2 samples all come from row 479.
- start pulsed at cycles 10 and 93 during an active window: ignored, and exactly one done is seen. A start at cycle 94 begins a new window, with imgrad_rst at cycle 95.
- reset asserted at stream cycle 50: the next cycle has enable=0, busy=0, mem_rd=0 and in0..in2=0, with no done. A fresh start afterwards produces the full ramp-image results above.
- Two back-to-back windows, centres (100,200) and (101,200): the second window's stream equals the first shifted down by one row. imgrad_rst pulses once per window.
